cu_multicycle: RTL and testbench
================================

# cu_multicycle

Parametrised multi-cycle control unit for the simple CPU. It accepts one instruction at a time over a valid/ready handshake, sequences DECODE/EXECUTE/MEM/WRITEBACK, drives ALU and data-memory control, and writes results back into an internal register file of configurable depth. Compared with the first-generation CU it adds a fetch handshake, a completion pulse, an optional hard-wired zero register and a debug read port. Store instructions do not write back.

## Interface
- DATA_WIDTH, 8, operand/result/offset width
- REG_BITS, 2, register index width; register file depth = 2**REG_BITS
- ZERO_REG, 0, when 1, register 0 always reads 0 and writes to it are discarded
- INSTR_WIDTH, 2+3*REG_BITS+DATA_WIDTH+4 (=20 with the defaults), derived and not overridden

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  synchronous active-high reset
- instr  in  INSTR_WIDTH  fields MSB→LSB: type[2], rd, rs1, rs2 (REG_BITS each), offset[DATA_WIDTH], opcode[4]
- instr_valid  in  1  instr is presented
- instr_ready  out  1  high in IDLE with rst low; a transfer happens when valid&&ready at an edge
- result2  in  DATA_WIDTH  write-back data (ALU result or memory data_out)
- operand1, operand2  out  DATA_WIDTH  register-sourced operands
- offset  out  DATA_WIDTH  immediate offset
- opcode  out  4  ALU opcode
- sel1  out  1  1 = ALU result path, 0 = memory data_out path
- sel3  out  1  1 = pass offset to the address adder
- w_r  out  1  data memory write enable
- done  out  1  one-cycle pulse when an instruction retires
- dbg_addr  in  REG_BITS  debug register index
- dbg_data  out  DATA_WIDTH  combinational read of regfile[dbg_addr], with ZERO_REG applied

## Operation
- Type encoding: 00 = NOP, 01 = std_op, 10 = loadR, 11 = storeR.
- States: IDLE, DECODE, EXECUTE, MEM, WRITEBACK. Unknown encodings go to IDLE.
- IDLE: on handshake, latch instr.
  - type 00 is consumed and discarded: stay IDLE, no done.
  - any other type goes to DECODE.
- DECODE → EXECUTE. At this edge, register all control outputs:
  - std_op: operand1=R[rs1], operand2=R[rs2], sel1=1, sel3=0, w_r=0.
  - loadR: operand1=R[rs1], operand2=R[rd], sel1=0, sel3=1, w_r=0.
  - storeR: operand1=R[rs1], operand2=R[rd], sel1=1, sel3=1, w_r=1.
  - offset and opcode come from the instruction fields in all cases.
- EXECUTE transitions:
  - std_op → WRITEBACK.
  - loadR or storeR → MEM.
  - All outputs are held.
- MEM transitions:
  - loadR → WRITEBACK.
  - storeR → IDLE: w_r drops to 0 at this edge and done=1.
- WRITEBACK: regfile[rd] <= result2 (skipped when ZERO_REG && rd==0); done=1; → IDLE.
- On entry to IDLE: w_r=0 and done falls after one cycle. Other outputs hold their last values.
- Operands read the register file as it stands at the DECODE edge. No forwarding is needed because instructions never overlap.

## Timing
- Reset values (rst high at an edge):
  - state=IDLE.
  - operand1=operand2=offset=0, opcode=4'b1111.
  - sel1=sel3=w_r=done=0.
  - regfile[i]=i, truncated to DATA_WIDTH.
  - instr_ready=0 while rst is high.
- Reset wins over every state; a mid-instruction reset aborts the instruction with no write-back.
- Let N be the accepting edge:
  - Outputs are valid from edge N+1.
  - std_op: write at N+3, done high N+3..N+4, next accept possible at N+4.
  - loadR: write at N+4, done high N+4..N+5, next accept at N+5.
  - storeR: w_r high N+1..N+3 (two cycles), done high N+3..N+4, next accept at N+4.
- instr_ready is low from N until re-entry to IDLE. instr is ignored while ready is low.
- A write-back edge followed by a dbg read shows the new value in the cycle after the edge.

## Test plan
- Reset, then dbg sweep over all indices → dbg_data=i; opcode=4'hF, w_r=0, instr_ready=1 after rst falls.
- std_op rd=1, rs1=2, rs2=3, opcode=4'h2, result2=8'h05 → operand1=2 and operand2=3 at N+1, R1=5 at N+3, done pulses once at N+3.
- loadR rd=3, rs1=1, offset=8'h10, result2=8'hAA → sel1=0, sel3=1, w_r=0; R3=AA at N+4; done at N+4.
- storeR rd=2, rs1=0, offset=8'h04 → w_r=1 for exactly 2 cycles; no register changes; done at N+3.
- NOP, then std_op presented back-to-back with valid held high → NOP consumed silently, std_op accepted on the next edge; instr changes while ready=0 have no effect.
- ZERO_REG=1, std_op rd=0, result2=8'h7F → dbg R0=0. Also assert rst at N+2 of a loadR → no write-back, all outputs return to reset values.

Source files
------------

// File: rtl/cu_multicycle.sv
// rtl/cu_multicycle.sv - multi-cycle control unit with fetch handshake, register file and debug read port
module cu_multicycle #(
  parameter int DATA_WIDTH = 8,
  parameter int REG_BITS   = 2,
  parameter bit ZERO_REG   = 1'b0,
  localparam int INSTR_WIDTH = 2 + 3*REG_BITS + DATA_WIDTH + 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INSTR_WIDTH-1:0] instr,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  input  logic [DATA_WIDTH-1:0]  result2,
  output logic [DATA_WIDTH-1:0]  operand1,
  output logic [DATA_WIDTH-1:0]  operand2,
  output logic [DATA_WIDTH-1:0]  offset,
  output logic [3:0]             opcode,
  output logic                   sel1,
  output logic                   sel3,
  output logic                   w_r,
  output logic                   done,
  input  logic [REG_BITS-1:0]    dbg_addr,
  output logic [DATA_WIDTH-1:0]  dbg_data
);

  localparam int DEPTH    = 2**REG_BITS;
  localparam int TYPE_MSB = INSTR_WIDTH - 1;
  localparam int RD_MSB   = INSTR_WIDTH - 3;
  localparam int RS1_MSB  = RD_MSB - REG_BITS;
  localparam int RS2_MSB  = RS1_MSB - REG_BITS;
  localparam int OFF_LSB  = 4;

  localparam logic [1:0] T_NOP   = 2'b00;
  localparam logic [1:0] T_STD   = 2'b01;
  localparam logic [1:0] T_LOAD  = 2'b10;
  localparam logic [1:0] T_STORE = 2'b11;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4
  } state_t;

  state_t state;
  state_t state_next;

  logic [INSTR_WIDTH-1:0] instr_q;
  logic [INSTR_WIDTH-1:0] instr_next;

  logic [DATA_WIDTH-1:0] operand1_next;
  logic [DATA_WIDTH-1:0] operand2_next;
  logic [DATA_WIDTH-1:0] offset_next;
  logic [3:0]            opcode_next;
  logic                  sel1_next;
  logic                  sel3_next;
  logic                  w_r_next;
  logic                  done_next;
  logic                  rf_we;

  logic [DATA_WIDTH-1:0] regs    [DEPTH];
  logic [DATA_WIDTH-1:0] rf_view [DEPTH];

  // Fields of the latched instruction; they stay stable for its whole lifetime
  logic [1:0]            itype;
  logic [REG_BITS-1:0]   rd_f;
  logic [REG_BITS-1:0]   rs1_f;
  logic [REG_BITS-1:0]   rs2_f;
  logic [DATA_WIDTH-1:0] off_f;
  logic [3:0]            opc_f;

  assign itype = instr_q[TYPE_MSB -: 2];
  assign rd_f  = instr_q[RD_MSB -: REG_BITS];
  assign rs1_f = instr_q[RS1_MSB -: REG_BITS];
  assign rs2_f = instr_q[RS2_MSB -: REG_BITS];
  assign off_f = instr_q[OFF_LSB +: DATA_WIDTH];
  assign opc_f = instr_q[3:0];

  // Only IDLE fetches, and never while reset is being applied
  assign instr_ready = (state == IDLE) && !rst;

  // Architectural view of the register file: R0 reads as zero when hard-wired
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rf_view[i] = (ZERO_REG && (i == 0)) ? '0 : regs[i];
    end
  end

  assign dbg_data = rf_view[dbg_addr];

  // Next-state and next-output decisions; every output holds unless changed here
  always_comb begin
    state_next    = state;
    instr_next    = instr_q;
    operand1_next = operand1;
    operand2_next = operand2;
    offset_next   = offset;
    opcode_next   = opcode;
    sel1_next     = sel1;
    sel3_next     = sel3;
    w_r_next      = w_r;
    done_next     = 1'b0;
    rf_we         = 1'b0;

    case (state)
      IDLE: begin
        w_r_next = 1'b0;
        if (instr_valid && instr_ready) begin
          instr_next = instr;
          // A NOP is swallowed here: it never reaches DECODE and never retires
          if (instr[TYPE_MSB -: 2] != T_NOP) begin
            state_next = DECODE;
          end
        end
      end

      DECODE: begin
        state_next    = EXECUTE;
        operand1_next = rf_view[rs1_f];
        offset_next   = off_f;
        opcode_next   = opc_f;
        case (itype)
          T_STD: begin
            operand2_next = rf_view[rs2_f];
            sel1_next     = 1'b1;
            sel3_next     = 1'b0;
            w_r_next      = 1'b0;
          end
          T_LOAD: begin
            operand2_next = rf_view[rd_f];
            sel1_next     = 1'b0;
            sel3_next     = 1'b1;
            w_r_next      = 1'b0;
          end
          T_STORE: begin
            operand2_next = rf_view[rd_f];
            sel1_next     = 1'b1;
            sel3_next     = 1'b1;
            w_r_next      = 1'b1;
          end
          default: begin
            state_next = IDLE;
          end
        endcase
      end

      EXECUTE: begin
        case (itype)
          T_STD:           state_next = WRITEBACK;
          T_LOAD, T_STORE: state_next = MEM;
          default:         state_next = IDLE;
        endcase
      end

      MEM: begin
        if (itype == T_LOAD) begin
          state_next = WRITEBACK;
        end else begin
          // Stores retire straight from MEM: the write strobe ends here
          state_next = IDLE;
          w_r_next   = 1'b0;
          done_next  = (itype == T_STORE);
        end
      end

      WRITEBACK: begin
        rf_we      = !(ZERO_REG && (rd_f == '0));
        done_next  = 1'b1;
        w_r_next   = 1'b0;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
        w_r_next   = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Registered control outputs and the latched instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q  <= '0;
      operand1 <= '0;
      operand2 <= '0;
      offset   <= '0;
      opcode   <= 4'hF;
      sel1     <= 1'b0;
      sel3     <= 1'b0;
      w_r      <= 1'b0;
      done     <= 1'b0;
    end else begin
      instr_q  <= instr_next;
      operand1 <= operand1_next;
      operand2 <= operand2_next;
      offset   <= offset_next;
      opcode   <= opcode_next;
      sel1     <= sel1_next;
      sel3     <= sel3_next;
      w_r      <= w_r_next;
      done     <= done_next;
    end
  end

  // Register file: reset loads each entry with its own index
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= DATA_WIDTH'(i);
      end
    end else if (rf_we) begin
      regs[rd_f] <= result2;
    end
  end

endmodule

// File: tb/tb_cu_multicycle.sv
// tb/tb_cu_multicycle.sv - scoreboard bench for cu_multicycle
module tb_cu_multicycle;

  localparam int DW = 8;
  localparam int RB = 2;
  localparam int IW = 2 + 3*RB + DW + 4;

  localparam logic [1:0] T_NOP   = 2'b00;
  localparam logic [1:0] T_STD   = 2'b01;
  localparam logic [1:0] T_LOAD  = 2'b10;
  localparam logic [1:0] T_STORE = 2'b11;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] instr;
  logic          instr_valid;
  logic [DW-1:0] result2;
  logic [RB-1:0] dbg_addr;

  logic          instr_ready, sel1, sel3, w_r, done;
  logic [DW-1:0] operand1, operand2, offset, dbg_data;
  logic [3:0]    opcode;

  logic          z_instr_ready, z_sel1, z_sel3, z_w_r, z_done;
  logic [DW-1:0] z_operand1, z_operand2, z_offset, z_dbg_data;
  logic [3:0]    z_opcode;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    logic [DW-1:0] off;
    logic [3:0]    opc;
    logic          s1;
    logic          s3;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] model_r  [4];
  logic [DW-1:0] model_rz [4];

  always #5 clk = ~clk;

  cu_multicycle #(.DATA_WIDTH(DW), .REG_BITS(RB), .ZERO_REG(1'b0)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .result2(result2), .operand1(operand1),
    .operand2(operand2), .offset(offset), .opcode(opcode), .sel1(sel1),
    .sel3(sel3), .w_r(w_r), .done(done), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  cu_multicycle #(.DATA_WIDTH(DW), .REG_BITS(RB), .ZERO_REG(1'b1)) dut_z (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(z_instr_ready), .result2(result2), .operand1(z_operand1),
    .operand2(z_operand2), .offset(z_offset), .opcode(z_opcode), .sel1(z_sel1),
    .sel3(z_sel3), .w_r(z_w_r), .done(z_done), .dbg_addr(dbg_addr), .dbg_data(z_dbg_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [IW-1:0] mk(input logic [1:0] t, input logic [RB-1:0] rd,
                                       input logic [RB-1:0] rs1, input logic [RB-1:0] rs2,
                                       input logic [DW-1:0] off, input logic [3:0] op);
    return {t, rd, rs1, rs2, off, op};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      model_r[i]  = DW'(i);
      model_rz[i] = (i == 0) ? '0 : DW'(i);
    end
  endtask

  task automatic dbg_sweep(input string tag);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = RB'(i);
      #1;
      check({tag, "_dbg"}, 32'(dbg_data), 32'(model_r[i]));
      check({tag, "_dbg_z"}, 32'(z_dbg_data), 32'(model_rz[i]));
    end
  endtask

  // Retirement monitor: every done pulse must match the oldest outstanding instruction
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_done", 32'(done), 32'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_operand1", 32'(operand1), 32'(e.op1));
        check("sb_operand2", 32'(operand2), 32'(e.op2));
        check("sb_offset", 32'(offset), 32'(e.off));
        check("sb_opcode", 32'(opcode), 32'(e.opc));
        check("sb_sel1", 32'(sel1), 32'(e.s1));
        check("sb_sel3", 32'(sel3), 32'(e.s3));
        check("sb_w_r", 32'(w_r), 32'(0));
      end
    end
  end

  task automatic accept(input logic [IW-1:0] ins);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!instr_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!instr_ready) check("accept_timeout", 32'(instr_ready), 32'(1));
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  // Cycle-by-cycle expectations after the accepting edge N; cycle c sits between N+c and N+c+1
  task automatic follow(input logic [1:0] t, input logic [RB-1:0] rd, input logic [RB-1:0] rs1,
                        input logic [RB-1:0] rs2, input logic [DW-1:0] off,
                        input logic [3:0] op, input logic [DW-1:0] res);
    int lat;
    exp_t e;
    logic [DW-1:0] old_r, old_rz;
    lat = (t == T_LOAD) ? 4 : 3;
    result2 = res;
    e.op1 = model_r[rs1];
    e.op2 = (t == T_STD) ? model_r[rs2] : model_r[rd];
    e.off = off;
    e.opc = op;
    e.s1  = (t != T_LOAD);
    e.s3  = (t != T_STD);
    exp_q.push_back(e);
    dbg_addr = rd;
    old_r  = model_r[rd];
    old_rz = model_rz[rd];
    if (t != T_STORE) begin
      model_r[rd] = res;
      if (rd != '0) model_rz[rd] = res;
    end
    for (int c = 0; c <= lat + 1; c++) begin
      @(negedge clk);
      check($sformatf("ready_c%0d", c), 32'(instr_ready), 32'(c >= lat && c <= lat + 1));
      check($sformatf("done_c%0d", c), 32'(done), 32'(c == lat));
      check($sformatf("w_r_c%0d", c), 32'(w_r), 32'((t == T_STORE) && (c == 1 || c == 2)));
      if (c == 1) begin
        check("n1_operand1", 32'(operand1), 32'(e.op1));
        check("n1_operand2", 32'(operand2), 32'(e.op2));
        check("n1_offset", 32'(offset), 32'(off));
        check("n1_opcode", 32'(opcode), 32'(op));
        check("n1_sel1", 32'(sel1), 32'(e.s1));
        check("n1_sel3", 32'(sel3), 32'(e.s3));
      end
      if (c == lat - 1) begin
        check("pre_wb_dbg", 32'(dbg_data), 32'(old_r));
        check("pre_wb_dbg_z", 32'(z_dbg_data), 32'(old_rz));
      end
      if (c == lat) begin
        check("post_wb_dbg", 32'(dbg_data), 32'(model_r[rd]));
        check("post_wb_dbg_z", 32'(z_dbg_data), 32'(model_rz[rd]));
      end
      // Junk on instr with valid high while ready is low must be ignored
      if (c < lat - 1) begin
        instr = IW'($urandom);
        instr_valid = 1'b1;
      end else begin
        instr_valid = 1'b0;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_operand1"}, 32'(operand1), 32'(0));
    check({tag, "_operand2"}, 32'(operand2), 32'(0));
    check({tag, "_offset"}, 32'(offset), 32'(0));
    check({tag, "_opcode"}, 32'(opcode), 32'(4'hF));
    check({tag, "_sel1"}, 32'(sel1), 32'(0));
    check({tag, "_sel3"}, 32'(sel3), 32'(0));
    check({tag, "_w_r"}, 32'(w_r), 32'(0));
    check({tag, "_done"}, 32'(done), 32'(0));
    check({tag, "_ready"}, 32'(instr_ready), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    instr = '0;
    instr_valid = 1'b0;
    result2 = '0;
    dbg_addr = '0;
    model_reset();

    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(instr_ready), 32'(1));
    check("idle_opcode", 32'(opcode), 32'(4'hF));
    check("idle_w_r", 32'(w_r), 32'(0));
    dbg_sweep("reset");

    // std_op
    accept(mk(T_STD, 2'd1, 2'd2, 2'd3, 8'h33, 4'h2));
    follow(T_STD, 2'd1, 2'd2, 2'd3, 8'h33, 4'h2, 8'h05);

    // loadR
    accept(mk(T_LOAD, 2'd3, 2'd1, 2'd0, 8'h10, 4'h0));
    follow(T_LOAD, 2'd3, 2'd1, 2'd0, 8'h10, 4'h0, 8'hAA);

    // storeR: result2 is deliberately non-zero and must not land anywhere
    accept(mk(T_STORE, 2'd2, 2'd0, 2'd1, 8'h04, 4'h0));
    follow(T_STORE, 2'd2, 2'd0, 2'd1, 8'h04, 4'h0, 8'h5A);
    dbg_sweep("store");

    // NOP followed back-to-back by std_op with valid held high
    @(negedge clk);
    instr = mk(T_NOP, 2'd1, 2'd1, 2'd1, 8'hFF, 4'h7);
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr = mk(T_STD, 2'd2, 2'd3, 2'd1, 8'h07, 4'h5);
    @(negedge clk);
    check("nop_ready", 32'(instr_ready), 32'(1));
    check("nop_done", 32'(done), 32'(0));
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    follow(T_STD, 2'd2, 2'd3, 2'd1, 8'h07, 4'h5, 8'h11);

    // Write to R0: lands in the plain instance, discarded in the zero-register one
    accept(mk(T_STD, 2'd0, 2'd1, 2'd2, 8'h00, 4'h1));
    follow(T_STD, 2'd0, 2'd1, 2'd2, 8'h00, 4'h1, 8'h7F);
    dbg_sweep("zero");

    // Reset at N+2 of a loadR aborts it
    accept(mk(T_LOAD, 2'd2, 2'd1, 2'd0, 8'h20, 4'h3));
    result2 = 8'hEE;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort");
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("abort_no_done_c%0d", c), 32'(done), 32'(0));
    end
    dbg_sweep("abort");

    check("sb_drained", 32'(exp_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
